// File: rtl/instr_fetch_if.sv
// Program memory bus between the fetch front end and the 2-cycle icache port.
// Requests and addresses are registered by the consumer; data returns two cycles later.
interface program_memory_bus;
    logic [31:0] addr;
    logic        read_request;
    logic [31:0] instr;
    logic        data_valid;

    modport CONSUMER_A (
        output addr,
        output read_request,
        input  instr,
        input  data_valid
    );

    modport MEMORY (
        input  addr,
        input  read_request,
        output instr,
        output data_valid
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch front end: sequential fetch into a 2-cycle icache, shadow pipe for
// in-flight requests, output FIFO towards decode, redirect kill/flush.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    program_memory_bus.CONSUMER_A bus,
    input  logic                  redirect_in,
    input  logic [31:0]           redirect_pc_in,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [31:0]           pc_out,
    output logic [31:0]           instr_out
);

    localparam int          PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CW       = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] PC_MASK  = 32'hFFFF_FFFC;
    localparam logic [31:0] START_PC = RESET_PC & PC_MASK;

    logic [31:0]   fetch_pc;
    logic          s0_live;
    logic          s1_live;
    logic          s2_live;
    logic [31:0]   s0_pc;
    logic [31:0]   s1_pc;
    logic [31:0]   s2_pc;

    logic [31:0]   pc_mem    [FIFO_DEPTH];
    logic [31:0]   instr_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          empty;
    logic          pop;
    logic          pop_eff;
    logic          push;
    logic          issue;
    logic [5:0]    total;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign pop     = !empty && ready_in;
    assign pop_eff = pop && !redirect_in;
    assign push    = bus.data_valid && s2_live && !redirect_in;

    // Counting every live slot reserves a FIFO entry for each fetch in flight.
    assign total = 6'(count) - 6'(pop)
                 + 6'(s0_live) + 6'(s1_live) + 6'(s2_live);
    assign issue = !redirect_in && (total < 6'(FIFO_DEPTH));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            fetch_pc         <= START_PC;
            bus.read_request <= 1'b0;
            bus.addr         <= START_PC;
            s0_live          <= 1'b0;
            s1_live          <= 1'b0;
            s2_live          <= 1'b0;
            s0_pc            <= '0;
            s1_pc            <= '0;
            s2_pc            <= '0;
        end else begin
            bus.read_request <= issue;
            s0_live          <= issue;
            s1_live          <= s0_live && !redirect_in;
            s2_live          <= s1_live && !redirect_in;
            s1_pc            <= s0_pc;
            s2_pc            <= s1_pc;
            if (redirect_in) begin
                fetch_pc <= redirect_pc_in & PC_MASK;
            end else if (issue) begin
                bus.addr <= fetch_pc;
                s0_pc    <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_eff) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop_eff);
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            pc_mem[wr_ptr]    <= s2_pc;
            instr_mem[wr_ptr] <= bus.instr;
        end
    end

    // Outputs read zero when empty so no stale entry is ever visible.
    assign valid_out = !empty;
    assign pc_out    = empty ? '0 : pc_mem[rd_ptr];
    assign instr_out = empty ? '0 : instr_mem[rd_ptr];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: queue scoreboard fed by a sequential-pc reference
// stream, directed latency/stall/redirect/wrap scenarios and a random soak.
module tb_instr_fetch;

    localparam logic [31:0] K     = 32'hA5A5_0000;
    localparam logic [31:0] RPC_B = 32'hFFFF_FFF8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst_nb;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ready;
    logic        valid_a;
    logic [31:0] pc_a;
    logic [31:0] instr_a;
    logic        valid_b;
    logic [31:0] pc_b;
    logic [31:0] instr_b;

    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;
    int idx_b = 0;

    item_t       exp_q[$];
    logic [31:0] gen_pc;

    always #5 clk = ~clk;

    program_memory_bus bus_a();
    program_memory_bus bus_b();

    instr_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .bus(bus_a),
        .redirect_in(redirect), .redirect_pc_in(redirect_pc),
        .valid_out(valid_a), .ready_in(ready),
        .pc_out(pc_a), .instr_out(instr_a)
    );

    instr_fetch #(.RESET_PC(RPC_B), .FIFO_DEPTH(4)) dut_b (
        .clk_in(clk), .rst_n_in(rst_nb), .bus(bus_b),
        .redirect_in(1'b0), .redirect_pc_in(32'h0),
        .valid_out(valid_b), .ready_in(1'b1),
        .pc_out(pc_b), .instr_out(instr_b)
    );

    // Icache models: a request seen in cycle N answers in cycle N+2.
    logic        a_d0v = 1'b0, a_d1v = 1'b0;
    logic [31:0] a_d0i = '0,   a_d1i = '0;
    logic        b_d0v = 1'b0, b_d1v = 1'b0;
    logic [31:0] b_d0i = '0,   b_d1i = '0;

    always @(posedge clk) begin
        #1;
        bus_a.data_valid = a_d1v;
        bus_a.instr      = a_d1v ? a_d1i : $urandom;
        a_d1v = a_d0v;
        a_d1i = a_d0i;
        a_d0v = bus_a.read_request;
        a_d0i = bus_a.addr ^ K;
        bus_b.data_valid = b_d1v;
        bus_b.instr      = b_d1v ? b_d1i : $urandom;
        b_d1v = b_d0v;
        b_d1i = b_d0i;
        b_d0v = bus_b.read_request;
        b_d0i = bus_b.addr ^ K;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic refill();
        item_t it;
        while (exp_q.size() < 8) begin
            it.pc    = gen_pc;
            it.instr = gen_pc ^ K;
            exp_q.push_back(it);
            gen_pc += 32'd4;
        end
    endtask

    task automatic restart_model(input logic [31:0] pc);
        exp_q.delete();
        gen_pc = pc & 32'hFFFF_FFFC;
        refill();
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        redirect = 1'b0;
        refill();
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        restart_model(pc);
    endtask

    task automatic wait_req(input string nm, input logic [31:0] a,
                            input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            if (bus_a.read_request) begin
                chk(nm, bus_a.addr, a);
                got = 1'b1;
            end else begin
                tick();
                #1;
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no request in %0d cycles, expected addr %h",
                     nm, budget, a);
        end
    endtask

    // Scoreboard monitor: pops on every accepted handshake, checks stall hold.
    logic        held = 1'b0;
    logic [31:0] held_pc, held_instr;
    item_t       got_it;

    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("stall_valid", 32'(valid_a), 32'd1);
                chk("stall_pc", pc_a, held_pc);
                chk("stall_instr", instr_a, held_instr);
            end
            held = 1'b0;
            if (!redirect && valid_a) begin
                if (ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL sb_empty: got pc %h, nothing expected", pc_a);
                    end else begin
                        got_it = exp_q.pop_front();
                        chk("sb_pc", pc_a, got_it.pc);
                        chk("sb_instr", instr_a, got_it.instr);
                        n_out++;
                    end
                end else begin
                    held       = 1'b1;
                    held_pc    = pc_a;
                    held_instr = instr_a;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_nb && valid_b && idx_b < 4) begin
            chk("wrap_pc", pc_b, RPC_B + 32'(idx_b * 4));
            chk("wrap_instr", instr_b, (RPC_B + 32'(idx_b * 4)) ^ K);
            idx_b++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        int nreq;
        int out0;
        logic [31:0] rpc;
        rst_n       = 1'b0;
        rst_nb      = 1'b0;
        ready       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        gen_pc      = '0;
        repeat (3) tick();

        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_pc", pc_a, 32'd0);
        chk("rst_instr", instr_a, 32'd0);
        chk("rst_req", 32'(bus_a.read_request), 32'd0);
        chk("rst_addr", bus_a.addr, 32'd0);
        chk("rst_addr_b", bus_b.addr, RPC_B);
        chk("rst_valid_b", 32'(valid_b), 32'd0);

        // Streaming with ready held high
        restart_model(32'h0);
        rst_n  = 1'b1;
        rst_nb = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            #1;
            if (c == 1) chk("t1_req", 32'(bus_a.read_request), 32'd1);
            if (c < 4) chk("t1_early_valid", 32'(valid_a), 32'd0);
            else chk("t1_no_bubble", 32'(valid_a), 32'd1);
            if (c == 4) chk("t1_first_pc", pc_a, 32'd0);
        end

        // Stalled decode from reset; the short reset leaves stray responses
        ready = 1'b0;
        rst_n = 1'b0;
        restart_model(32'h0);
        tick();
        rst_n = 1'b1;
        nreq  = 0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            #1;
            if (bus_a.read_request) begin
                chk("t2_addr", bus_a.addr, 32'(nreq * 4));
                nreq++;
            end
        end
        chk("t2_req_count", 32'(nreq), 32'd4);
        chk("t2_head_valid", 32'(valid_a), 32'd1);
        chk("t2_head_pc", pc_a, 32'd0);
        ready = 1'b1;
        wait_req("t2_resume_addr", 32'd16, 8);

        // Redirect with fetches in flight and entries buffered
        repeat (10) tick();
        ready = 1'b0;
        tick();
        ready = 1'b1;
        do_redirect(32'h0000_0103);
        tick();
        #1;
        chk("t3_flush", 32'(valid_a), 32'd0);
        wait_req("t3_addr", 32'h0000_0100, 6);
        repeat (8) tick();

        // Redirect colliding with an arriving response and a pop
        chk("t4_dv", 32'(bus_a.data_valid), 32'd1);
        chk("t4_valid", 32'(valid_a), 32'd1);
        do_redirect(32'h0000_2000);
        repeat (6) tick();
        do_redirect(32'h0000_3000);
        tick();
        do_redirect(32'h0000_4000);
        tick();
        #1;
        wait_req("t4_last_wins", 32'h0000_4000, 6);
        repeat (8) tick();

        // Random soak
        out0 = n_out;
        for (int i = 0; i < 10000; i++) begin
            tick();
            ready = 1'($urandom % 2);
            if ($urandom % 64 == 0) begin
                if ($urandom % 4 == 0) rpc = 32'hFFFF_FFE0 + ($urandom % 32);
                else rpc = $urandom;
                do_redirect(rpc);
            end
        end
        chk("t6_enough_outputs", 32'(n_out - out0 > 2000), 32'd1);

        repeat (4) tick();
        chk("t5_wrap_count", 32'(idx_b), 32'd4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
